// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: picks a mole cell each round, times its display,
// judges keypad presses against it and keeps the score for the VGA driver.
module mole_game_ctrl #(
    parameter int         MOLE_TICKS = 25_000_000,
    parameter int         HIT_TICKS  = 12_500_000,
    parameter int         ROUNDS     = 20,
    parameter logic [7:0] SEED       = 8'hA5
) (
    input  logic       clk25MHz,
    input  logic       rst,
    input  logic       start,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       inGame,
    output logic       hit,
    output logic [3:0] position,
    output logic [4:0] score,
    output logic       done
);

    localparam int MAX_TICKS = (MOLE_TICKS > HIT_TICKS) ? MOLE_TICKS : HIT_TICKS;
    localparam int TW        = $clog2(MAX_TICKS + 1);
    localparam logic [TW-1:0] MOLE_LAST = TW'(MOLE_TICKS - 1);
    localparam logic [TW-1:0] HIT_LAST  = TW'(HIT_TICKS - 1);
    localparam logic [4:0]    ROUNDS_L  = 5'(ROUNDS);

    typedef enum logic [1:0] {IDLE, SHOW, HITHOLD, OVER} state_t;

    state_t        state_reg, state_next;
    logic [7:0]    lfsr_reg, lfsr_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [4:0]    round_reg, round_next;
    logic          in_game_reg, in_game_next;
    logic          hit_reg, hit_next;
    logic [3:0]    position_reg, position_next;
    logic [4:0]    score_reg, score_next;
    logic          done_reg, done_next;

    logic [3:0] cand;
    logic [3:0] pick;
    logic [4:0] round_inc;
    logic       key_hit;
    logic       begin_game;
    logic       end_round;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1; free-running in every state
    assign lfsr_next[0] = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
    for (genvar gi = 1; gi < 8; gi++) begin : g_shift
        assign lfsr_next[gi] = lfsr_reg[gi-1];
    end

    // Bumping a repeated cell by one keeps consecutive moles apart
    always_comb begin
        cand = 4'(lfsr_reg % 8'd9) + 4'd1;
        pick = cand;
        if (cand == position_reg)
            pick = (cand == 4'd9) ? 4'd1 : cand + 4'd1;
    end

    assign key_hit   = key_valid && (key_code == position_reg);
    assign round_inc = round_reg + 5'd1;

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        round_next    = round_reg;
        in_game_next  = in_game_reg;
        hit_next      = hit_reg;
        position_next = position_reg;
        score_next    = score_reg;
        done_next     = done_reg;
        begin_game    = 1'b0;
        end_round     = 1'b0;

        case (state_reg)
            IDLE, OVER: begin
                if (start)
                    begin_game = 1'b1;
            end
            SHOW: begin
                // A hit on the expiring cycle still counts
                if (key_hit) begin
                    state_next = HITHOLD;
                    hit_next   = 1'b1;
                    score_next = score_reg + 5'd1;
                    timer_next = '0;
                end else if (timer_reg == MOLE_LAST) begin
                    end_round = 1'b1;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            HITHOLD: begin
                if (timer_reg == HIT_LAST)
                    end_round = 1'b1;
                else
                    timer_next = timer_reg + TW'(1);
            end
            default: state_next = IDLE;
        endcase

        if (begin_game) begin
            state_next    = SHOW;
            position_next = pick;
            in_game_next  = 1'b1;
            hit_next      = 1'b0;
            score_next    = '0;
            done_next     = 1'b0;
            round_next    = '0;
            timer_next    = '0;
        end

        if (end_round) begin
            round_next = round_inc;
            timer_next = '0;
            hit_next   = 1'b0;
            if (round_inc == ROUNDS_L) begin
                state_next    = OVER;
                in_game_next  = 1'b0;
                position_next = '0;
                done_next     = 1'b1;
            end else begin
                state_next    = SHOW;
                position_next = pick;
            end
        end
    end

    always_ff @(posedge clk25MHz or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            lfsr_reg     <= SEED;
            timer_reg    <= '0;
            round_reg    <= '0;
            in_game_reg  <= 1'b0;
            hit_reg      <= 1'b0;
            position_reg <= '0;
            score_reg    <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lfsr_reg     <= lfsr_next;
            timer_reg    <= timer_next;
            round_reg    <= round_next;
            in_game_reg  <= in_game_next;
            hit_reg      <= hit_next;
            position_reg <= position_next;
            score_reg    <= score_next;
            done_reg     <= done_next;
        end
    end

    assign inGame   = in_game_reg;
    assign hit      = hit_reg;
    assign position = position_reg;
    assign score    = score_reg;
    assign done     = done_reg;

endmodule

// File: doc/mole_game_ctrl.md
# mole_game_ctrl

Game controller for the 3x3 whack-a-mole display, in the 25 MHz pixel-clock domain. Picks a pseudo-random cell 1–9 each round and times how long the mole is shown. Judges keypad presses against the mole's cell and keeps score. Drives the VGA driver's `inGame`, `hit` and `position` inputs directly, with no resynchronisation.

## Interface
- `MOLE_TICKS`, default 25_000_000: cycles a mole stays in SHOW (1 s).
- `HIT_TICKS`, default 12_500_000: cycles the red hit marker is held (0.5 s).
- `ROUNDS`, default 20: moles per game; range 1..31.
- `SEED`, default 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `clk25MHz` in 1: PLL c0, 25 MHz.
- `rst` in 1: asynchronous, active-low.
- `start` in 1: single-cycle pulse, already debounced and synchronous to `clk25MHz`.
- `key_valid` in 1: single-cycle pulse, synchronous; `key_code` is valid in that cycle.
- `key_code` in 4: pressed cell 1..9; values 0 and 10..15 never match.
- `inGame` out 1: game running.
- `hit` out 1: the current mole has been hit.
- `position` out 4: mole cell 1..9; 0 when no game is running.
- `score` out 5: count of hits in the current or last game.
- `done` out 1: last game finished.

## Operation
- Reset state: IDLE; `inGame`=0, `hit`=0, `position`=0, `score`=0, `done`=0, LFSR=`SEED`, timer=0, round counter=0. All outputs are registers.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Shifts every cycle from reset release, in all states.
  - Never reaches 0.
- Cell pick: `cand = (lfsr mod 9) + 1`.
  - If `cand` equals the current `position`: use `cand+1`, with 9 wrapping to 1.
  - Consecutive moles therefore never share a cell.
- State IDLE:
  - On `start`: go to SHOW; load `position` with the pick; `inGame`=1; `score`=0; `done`=0; round counter=0; timer=0.
- State SHOW: timer counts up each cycle.
  - `key_valid` with `key_code`==`position`: go to HITHOLD; `hit`=1; `score`+1; timer=0.
  - `key_valid` with any other code: ignored.
  - Timer reaches `MOLE_TICKS-1` with no hit: end of round (miss).
- State HITHOLD:
  - `position` held, `hit`=1; all keys ignored.
  - Timer reaches `HIT_TICKS-1`: end of round.
- End of round:
  - Round counter +1.
  - If the new count equals `ROUNDS`: go to OVER.
  - Otherwise: go to SHOW with a new pick; `hit`=0; timer=0.
- State OVER: `inGame`=0, `hit`=0, `position`=0, `done`=1, `score` held.
  - On `start`: same actions as `start` in IDLE.
- Arithmetic: timer is 25 bits, sized to `MOLE_TICKS`; compares use full width. `score` cannot exceed `ROUNDS`, so it never wraps.

## Timing
- `start` sampled in cycle N gives `inGame`=1 and a valid `position` in cycle N+1.
- A matching `key_valid` in cycle N gives `hit`=1 and the incremented `score` in N+1.
- Miss round: SHOW lasts exactly `MOLE_TICKS` cycles.
- Hit round: HITHOLD lasts exactly `HIT_TICKS` cycles. `hit` falls in the same cycle the new `position` appears.
- Matching key in the same cycle the SHOW timer expires: the hit wins (HITHOLD, score+1).
- `start` during SHOW or HITHOLD: ignored.
- `start` and `key_valid` together in IDLE/OVER: the key is ignored.
- `rst` asserted mid-game: all outputs go to reset values immediately (asynchronous). Operation resumes in IDLE after release.
- The LFSR value used for each pick depends on cycle count since reset; the bench computes the expected pick from a reference LFSR model.

## Test plan
Bench parameters unless stated: `MOLE_TICKS`=8, `HIT_TICKS`=4, `ROUNDS`=3, `SEED`=8'hA5.

- Reset/idle: hold `rst`=0, release, wait 20 cycles -> all outputs 0; `start` pulse -> next cycle `inGame`=1 and `position` = reference-model pick, in 1..9.
- All misses: `start`, no keys -> each `position` lasts 8 cycles and differs from the previous one; after 24 cycles `inGame`=0, `done`=1, `score`=0, `position`=0.
- All hits: press the matching `key_code` 2 cycles into every SHOW -> `hit`=1 for 4 cycles per round; final `score`=3, `done`=1.
- Wrong and late keys: wrong code in SHOW -> no change; correct code during HITHOLD -> `score` unchanged; correct code on the last SHOW cycle -> hit counted.
- Restart and mid-game start: `start` during SHOW -> ignored; `start` in OVER -> `score`=0, `done`=0, `inGame`=1 next cycle.
- Reset mid-HITHOLD: drop `rst` -> `hit`, `position`, `score` read 0 in the same cycle; after release the state is IDLE and LFSR=8'hA5.
